gerenciador_ataque_core: RTL and testbench

GERENCIADOR_ATAQUE_CORE -- requirements
Module: gerenciador_ataque_core

---
 rtl/gerenciador_ataque_core_pkg.sv | 15 +
 rtl/gerenciador_ataque_core_decodificador_3bits.sv | 15 +
 rtl/gerenciador_ataque_core.sv | 127 ++++++++++++
 tb/tb_gerenciador_ataque_core.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gerenciador_ataque_core_pkg.sv
// Shared sizes and types for the attack manager (gerenciador_ataque_core).
package gerenciador_ataque_core_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  localparam int COORD_W  = 3;
  localparam int DEC_W    = 1 << COORD_W;

  // One board column; bit n is row n, 1 = ship.
  typedef logic [NUM_ROWS-1:0] col_word_t;

  // Whole board, column-major, so boards compare with a single !=.
  typedef logic [NUM_COLS-1:0][NUM_ROWS-1:0] board_t;

endpackage

// File: rtl/gerenciador_ataque_core_decodificador_3bits.sv
// 3-bit binary to 8-bit one-hot decoder, used for both row and column select.
module decodificador_3bits
  import gerenciador_ataque_core_pkg::*;
(
  input  logic [COORD_W-1:0] sel,
  output logic [DEC_W-1:0]   one_hot
);

  // Exactly one output bit high for every input code.
  always_comb begin
    one_hot = '0;
    one_hot[sel] = 1'b1;
  end

endmodule

// File: rtl/gerenciador_ataque_core.sv
// Attack manager: reveals one board cell per confirm rising edge and reports
// hit/miss on the RGB status LEDs.
// Optional feature: define ATK_VICTORY_LED_EN to drive LED_B high once every
// ship cell has been revealed; otherwise LED_B is tied low.
module gerenciador_ataque_core
  import gerenciador_ataque_core_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] coordColuna,
  input  logic [COORD_W-1:0] coordLinha,
  input  logic               enable,
  input  logic               confirmar,
  input  col_word_t          mapa0,
  input  col_word_t          mapa1,
  input  col_word_t          mapa2,
  input  col_word_t          mapa3,
  input  col_word_t          mapa4,
  output col_word_t          matriz0,
  output col_word_t          matriz1,
  output col_word_t          matriz2,
  output col_word_t          matriz3,
  output col_word_t          matriz4,
  output logic               LED_R,
  output logic               LED_G,
  output logic               LED_B
);

  logic             confirm_q;
  logic             attack_evt;
  logic             coord_valid;
  logic             attack_ok;
  logic             hit;
  logic [DEC_W-1:0] col_oh;
  logic [DEC_W-1:0] row_oh;
  board_t           mapa_w;
  board_t           matriz_q;
  board_t           matriz_d;
  logic             led_r_q;
  logic             led_g_q;

  assign mapa_w = {mapa4, mapa3, mapa2, mapa1, mapa0};

  decodificador_3bits u_dec_coluna (
    .sel     (coordColuna),
    .one_hot (col_oh)
  );

  decodificador_3bits u_dec_linha (
    .sel     (coordLinha),
    .one_hot (row_oh)
  );

  // Rising edge of the level confirm input; a held-high confirm fires once.
  assign attack_evt = confirmar & ~confirm_q;

  // Codes beyond the board decode to the upper one-hot bits; those select no cell.
  assign coord_valid = ~|col_oh[DEC_W-1:NUM_COLS] & ~|row_oh[DEC_W-1:NUM_ROWS];
  assign attack_ok   = attack_evt & enable & coord_valid;

  // Next board: the addressed cell copies the hidden map, every other cell holds.
  always_comb begin
    matriz_d = matriz_q;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (attack_ok && col_oh[c] && row_oh[r]) begin
          matriz_d[c][r] = mapa_w[c][r];
        end
      end
    end
  end

  // A hit is any change of the whole board; miss and already-revealed look the same.
  assign hit = (matriz_d != matriz_q);

  // Confirm history, revealed board and hit/miss LEDs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      confirm_q <= 1'b0;
      matriz_q  <= '0;
      led_r_q   <= 1'b0;
      led_g_q   <= 1'b0;
    end else begin
      confirm_q <= confirmar;
      if (!enable) begin
        // Clearing wins over a simultaneous attack; the LEDs keep their status.
        matriz_q <= '0;
      end else begin
        matriz_q <= matriz_d;
        if (attack_evt) begin
          led_r_q <= ~hit;
          led_g_q <= hit;
        end
      end
    end
  end

  assign matriz0 = matriz_q[0];
  assign matriz1 = matriz_q[1];
  assign matriz2 = matriz_q[2];
  assign matriz3 = matriz_q[3];
  assign matriz4 = matriz_q[4];
  assign LED_R   = led_r_q;
  assign LED_G   = led_g_q;

`ifdef ATK_VICTORY_LED_EN
  logic led_b_q;
  logic victory;

  // Victory needs a non-empty map, otherwise an empty board would already "win".
  assign victory = (matriz_q == mapa_w) && (|mapa_w);

  // Re-evaluated every cycle, so it drops one edge after the board clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_b_q <= 1'b0;
    end else begin
      led_b_q <= victory;
    end
  end

  assign LED_B = led_b_q;
`else
  assign LED_B = 1'b0;
`endif

endmodule

// File: tb/tb_gerenciador_ataque_core.sv
// Self-checking bench for gerenciador_ataque_core: fixed scenario table,
// hand-written corner sequences, then randomized traffic against a board model.
module tb_gerenciador_ataque_core;

  logic       clk;
  logic       rst_n;
  logic [2:0] col;
  logic [2:0] row;
  logic       en;
  logic       conf;
  logic [6:0] tb_mapa [5];
  logic [6:0] mat [5];
  logic       led_r, led_g, led_b;

  int tests = 0;
  int fails = 0;

`ifdef ATK_VICTORY_LED_EN
  localparam logic VIC_EXP = 1'b1;
`else
  localparam logic VIC_EXP = 1'b0;
`endif

  // Reference model state
  logic [6:0] m_board [5];
  logic       m_prev, m_r, m_g, m_b;

  gerenciador_ataque_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coordColuna (col),
    .coordLinha  (row),
    .enable      (en),
    .confirmar   (conf),
    .mapa0       (tb_mapa[0]),
    .mapa1       (tb_mapa[1]),
    .mapa2       (tb_mapa[2]),
    .mapa3       (tb_mapa[3]),
    .mapa4       (tb_mapa[4]),
    .matriz0     (mat[0]),
    .matriz1     (mat[1]),
    .matriz2     (mat[2]),
    .matriz3     (mat[3]),
    .matriz4     (mat[4]),
    .LED_R       (led_r),
    .LED_G       (led_g),
    .LED_B       (led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 5; c++) m_board[c] = '0;
    m_prev = 1'b0;
    m_r = 1'b0;
    m_g = 1'b0;
    m_b = 1'b0;
  endtask

  // Advance the model from the inputs currently driven, then take one clock edge.
  task automatic step();
    logic atk, eq, any, nb;
    int   ci, ri;
    ci  = int'(col);
    ri  = int'(row);
    atk = conf && !m_prev;
    eq  = 1'b1;
    any = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (m_board[c] != tb_mapa[c]) eq = 1'b0;
      if (tb_mapa[c] != 7'd0) any = 1'b1;
    end
    if (!en) begin
      for (int c = 0; c < 5; c++) m_board[c] = '0;
    end else if (atk) begin
      if (ci < 5 && ri < 7) begin
        nb = tb_mapa[ci][ri];
        m_g = (nb != m_board[ci][ri]);
        m_r = !m_g;
        m_board[ci][ri] = nb;
      end else begin
        m_r = 1'b1;
        m_g = 1'b0;
      end
    end
    m_prev = conf;
    m_b = VIC_EXP & eq & any;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string name);
    for (int c = 0; c < 5; c++) chk($sformatf("%s_matriz%0d", name, c), 32'(mat[c]), 32'(m_board[c]));
    chk({name, "_led_r"}, 32'(led_r), 32'(m_r));
    chk({name, "_led_g"}, 32'(led_g), 32'(m_g));
    chk({name, "_led_b"}, 32'(led_b), 32'(m_b));
  endtask

  task automatic chk_board(input string name, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e4);
    chk({name, "_m0"}, 32'(mat[0]), 32'(e0));
    chk({name, "_m1"}, 32'(mat[1]), 32'(e1));
    chk({name, "_m2"}, 32'(mat[2]), 32'd0);
    chk({name, "_m3"}, 32'(mat[3]), 32'd0);
    chk({name, "_m4"}, 32'(mat[4]), 32'(e4));
  endtask

  task automatic pulse(input int c, input int r);
    col = 3'(c);
    row = 3'(r);
    conf = 1'b1;
    step();
  endtask

  typedef struct {
    int         c;
    int         r;
    logic [6:0] m0;
    logic [6:0] m1;
    logic [6:0] m4;
    logic       lr;
    logic       lg;
    string      name;
  } vec_t;

  vec_t vecs [6];
  int   ship_c [8];
  int   ship_r [8];

  initial begin
    vecs[0] = '{0, 0, 7'b0000001, 7'b0000000, 7'b0000000, 1'b0, 1'b1, "c0r0_hit"};
    vecs[1] = '{0, 1, 7'b0000001, 7'b0000000, 7'b0000000, 1'b1, 1'b0, "c0r1_miss"};
    vecs[2] = '{1, 5, 7'b0000001, 7'b0100000, 7'b0000000, 1'b0, 1'b1, "c1r5_hit"};
    vecs[3] = '{3, 5, 7'b0000001, 7'b0100000, 7'b0000000, 1'b1, 1'b0, "c3r5_miss"};
    vecs[4] = '{4, 6, 7'b0000001, 7'b0100000, 7'b1000000, 1'b0, 1'b1, "c4r6_hit"};
    vecs[5] = '{4, 6, 7'b0000001, 7'b0100000, 7'b1000000, 1'b1, 1'b0, "c4r6_repeat"};
    ship_c = '{0, 0, 0, 0, 1, 4, 4, 4};
    ship_r = '{0, 4, 5, 6, 5, 4, 5, 6};

    tb_mapa[0] = 7'b1110001;
    tb_mapa[1] = 7'b0100000;
    tb_mapa[2] = 7'b0000000;
    tb_mapa[3] = 7'b0000000;
    tb_mapa[4] = 7'b1110000;
    en   = 1'b1;
    col  = 3'd1;
    row  = 3'd0;
    conf = 1'b1;
    rst_n = 1'b0;
    model_reset();

    // Reset state; confirm already high during reset
    repeat (2) @(posedge clk);
    #1;
    chk_board("reset", 7'd0, 7'd0, 7'd0);
    chk("reset_led_r", 32'(led_r), 32'd0);
    chk("reset_led_g", 32'(led_g), 32'd0);
    chk("reset_led_b", 32'(led_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Confirm register left reset at 0, so the held-high confirm is one attack (a miss)
    step();
    chk_board("first_after_reset", 7'd0, 7'd0, 7'd0);
    chk("first_after_reset_led_r", 32'(led_r), 32'd1);
    conf = 1'b0;
    step();

    // Scenario table
    foreach (vecs[i]) begin
      pulse(vecs[i].c, vecs[i].r);
      chk_board(vecs[i].name, vecs[i].m0, vecs[i].m1, vecs[i].m4);
      chk({vecs[i].name, "_led_r"}, 32'(led_r), 32'(vecs[i].lr));
      chk({vecs[i].name, "_led_g"}, 32'(led_g), 32'(vecs[i].lg));
      conf = 1'b0;
      step();
      chk({vecs[i].name, "_led_r_hold"}, 32'(led_r), 32'(vecs[i].lr));
    end

    // Held confirm: one attack at col0 row4, later coordinates ignored
    pulse(0, 4);
    chk_board("hold_first", 7'b0010001, 7'b0100000, 7'b1000000);
    chk("hold_first_led_g", 32'(led_g), 32'd1);
    col = 3'd4;
    row = 3'd5;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_board($sformatf("hold_%0d", k), 7'b0010001, 7'b0100000, 7'b1000000);
    end
    conf = 1'b0;
    step();

    // enable low with a confirm rising edge in the same cycle
    en = 1'b0;
    pulse(4, 5);
    chk_board("en_low", 7'd0, 7'd0, 7'd0);
    chk("en_low_led_g", 32'(led_g), 32'd1);
    chk("en_low_led_r", 32'(led_r), 32'd0);
    en = 1'b1;
    conf = 1'b0;
    step();
    pulse(0, 0);
    chk_board("reattack", 7'b0000001, 7'd0, 7'd0);
    chk("reattack_led_g", 32'(led_g), 32'd1);
    conf = 1'b0;
    step();

    // Out-of-range coordinates
    pulse(6, 2);
    chk_board("col6", 7'b0000001, 7'd0, 7'd0);
    chk("col6_led_r", 32'(led_r), 32'd1);
    chk("col6_led_g", 32'(led_g), 32'd0);
    conf = 1'b0;
    step();
    pulse(1, 5);
    chk("c1r5_again_led_g", 32'(led_g), 32'd1);
    conf = 1'b0;
    step();
    pulse(2, 7);
    chk_board("row7", 7'b0000001, 7'b0100000, 7'd0);
    chk("row7_led_r", 32'(led_r), 32'd1);
    chk("row7_led_g", 32'(led_g), 32'd0);
    conf = 1'b0;
    step();

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk_board("async_rst", 7'd0, 7'd0, 7'd0);
    chk("async_rst_led_r", 32'(led_r), 32'd0);
    chk("async_rst_led_g", 32'(led_g), 32'd0);
    chk("async_rst_led_b", 32'(led_b), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Reveal all ship cells
    for (int i = 0; i < 8; i++) begin
      pulse(ship_c[i], ship_r[i]);
      chk_model($sformatf("ship_%0d", i));
      chk($sformatf("ship_%0d_led_g", i), 32'(led_g), 32'd1);
      conf = 1'b0;
      step();
    end
    chk("victory_led_b", 32'(led_b), 32'(VIC_EXP));
    en = 1'b0;
    step();
    chk_board("victory_clear", 7'd0, 7'd0, 7'd0);
    step();
    chk("victory_cleared_led_b", 32'(led_b), 32'd0);
    en = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int c = 0; c < 5; c++) tb_mapa[c] = 7'($urandom);
      end
      en   = ($urandom_range(0, 9) != 0);
      conf = 1'($urandom);
      col  = 3'($urandom_range(0, 7));
      row  = 3'($urandom_range(0, 7));
      step();
      chk_model($sformatf("rand_%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
